mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-ported memory arbiter sitting between the IF and MEM stages and one shared memory bus. It serialises instruction fetches and data accesses onto that bus. It generates the per-port RAM stall requests (`ram_stall_valid_if_o`, `ram_stall_valid_mem_o`) that the pipeline controller consumes. It buffers each completed response until the owning stage moves on, and it discards fetches that the pipeline flushes while they are in flight.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `TIMEOUT_CYCLES`, 255, watchdog limit (used only with `ARB_TIMEOUT_EN`)

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `if_req_i`  in  1  fetch request, held until the stage advances
- `if_addr_i`  in  ADDR_W  fetch address
- `if_flush_i`  in  1  IF stage flush
- `if_rdata_o`  out  DATA_W  fetched word
- `if_err_o`  out  1  fetch error, valid together with `if_rdata_o`
- `ram_stall_valid_if_o`  out  1  IF stall request
- `mem_req_i`  in  1  data request
- `mem_we_i`  in  1  1 = write
- `mem_addr_i`  in  ADDR_W  data address
- `mem_wdata_i`  in  DATA_W  write data
- `mem_wstrb_i`  in  DATA_W/8  byte strobes
- `mem_rdata_o`  out  DATA_W  load data
- `mem_err_o`  out  1  access error
- `ram_stall_valid_mem_o`  out  1  MEM stall request
- `bus_req_valid_o`  out  1  bus request valid
- `bus_req_ready_i`  in  1  bus accepts the request
- `bus_we_o`, `bus_addr_o`, `bus_wdata_o`, `bus_wstrb_o`  out  1, ADDR_W, DATA_W, DATA_W/8  request payload
- `bus_rsp_valid_i`  in  1  response valid
- `bus_rdata_i`  in  DATA_W  response data
- `bus_rsp_err_i`  in  1  response error

## Operation
**FSM states:** IDLE, REQ, WAIT, with an owner register (IF or MEM).

**IDLE**
- If `mem_req_i & ~mem_done`: latch the MEM payload, owner = MEM, go to REQ.
- Else if `if_req_i & ~if_done`: latch the IF payload, owner = IF, go to REQ.
- MEM wins simultaneous requests.

**REQ**
- `bus_req_valid_o` = 1 with the latched payload.
- The payload is stable until `bus_req_ready_i`; valid is never withdrawn, even on flush.
- On ready, go to WAIT.

**WAIT**
- On `bus_rsp_valid_i`, capture `bus_rdata_i` and `bus_rsp_err_i` into the owner's buffer, set the owner's `done`, return to IDLE.
- If the owner is IF and `discard` is set, drop the response, leave `done` at 0, return to IDLE.

**Discard**
- Set when `if_flush_i` is high while owner = IF in REQ or WAIT.
- Cleared on return to IDLE.

**Per-port buffer**
- `done` is set by a captured response.
- `done` is cleared when `req_i` = 0, when `addr_i` differs from the captured address, or (IF only) on `if_flush_i`.
- A held request with the same address does not re-issue.

**Stall outputs (combinational)**
- `ram_stall_valid_x_o = x_req_i & ~x_done`.

**Writes:** complete on response; `mem_rdata_o` is undefined after a write.

**Reset:**
- State returns to IDLE, owner = IF, `discard` = 0, both `done` = 0.
- `bus_req_valid_o`, `bus_we_o`, `bus_addr_o`, `bus_wdata_o`, `bus_wstrb_o`, `if_rdata_o`, `mem_rdata_o`, `if_err_o`, `mem_err_o` = 0.
- A reset during REQ or WAIT abandons the transaction; a later `bus_rsp_valid_i` in IDLE is ignored.

## Timing
- Request in IDLE at cycle 0 → `bus_req_valid_o` at cycle 1 (registered).
- Ready at cycle r → WAIT from r+1.
- `bus_rsp_valid_i` at cycle n → rdata and err valid, and stall low, at n+1.
- Minimum latency request-to-unstall: 3 cycles (ready in cycle 1, response in cycle 2).
- A pending IF request waits behind a complete MEM transaction. A back-to-back issue starts the cycle after return to IDLE.
- A response in REQ (before ready) is illegal and ignored.

## Configuration
**`ARB_TIMEOUT_EN` defined**
- A counter runs in REQ and WAIT and clears in IDLE.
- Reaching `TIMEOUT_CYCLES` aborts the transaction: the owner's `done` = 1, rdata = 0, err = 1, `bus_req_valid_o` dropped, return to IDLE.
- A late response arriving in IDLE is ignored.

**Not defined**
- No counter; the arbiter waits indefinitely.
- err comes only from `bus_rsp_err_i`.

## Structure
- Shared package: state enum (IDLE/REQ/WAIT), owner enum, `ADDR_W`/`DATA_W` defaults.
- Sub-module `arb_port_buf`, instantiated twice, holds the captured address, rdata, err and `done` flag, plus the clear logic.
- The top level holds the FSM, payload mux, discard flag and optional watchdog.

## Test plan
- IF-only fetch at 0x8000_0000, ready at cycle 1, rsp 0x0000_0013 at cycle 3 → `ram_stall_valid_if_o` high for cycles 0–3, `if_rdata_o` = 0x13 at cycle 4, no re-issue while the address is held.
- Simultaneous IF (0x100) and MEM load (0x2000) → MEM issues first, then IF; `ram_stall_valid_mem_o` drops before `ram_stall_valid_if_o`.
- `if_flush_i` during WAIT, then new address 0x200 → old response dropped, `if_done` stays 0, a fresh fetch to 0x200 is issued.
- MEM store with wdata 0xDEADBEEF, wstrb 0x3, ready held low for 5 cycles → payload stable and valid continuously high until ready.
- `bus_rsp_err_i` = 1 on a load → `mem_err_o` = 1 and stall released.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, no response → abort after 8 cycles with err = 1 and rdata = 0. Reset mid-WAIT → all outputs 0 and a stray response is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, bus owner, default widths.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_port_buf.sv
// Per-port response buffer: holds the completed response until the stage moves off
// the captured address, drops its request, or is flushed.
module arb_port_buf
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    input  logic              i_cap,
    input  logic [ADDR_W-1:0] i_cap_addr,
    input  logic [DATA_W-1:0] i_cap_rdata,
    input  logic              i_cap_err,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err
);

    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_clr;

    assign w_clr = ~i_req | (i_addr != r_addr) | i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (i_cap) begin
            r_done  <= 1'b1;
            r_addr  <= i_cap_addr;
            r_rdata <= i_cap_rdata;
            r_err   <= i_cap_err;
        end else if (w_clr) begin
            r_done  <= 1'b0;
        end
    end

    // Qualify with the clear terms so a stage that has just moved on never sees a stale done.
    assign o_done  = r_done & ~w_clr;
    assign o_rdata = r_rdata;
    assign o_err   = r_err;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM accesses onto one memory bus (MEM has priority).
// Optional watchdog abort is compiled in with ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,
    output logic                ram_stall_valid_if_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_err_o,
    output logic                ram_stall_valid_mem_o,
    output logic                bus_req_valid_o,
    input  logic                bus_req_ready_i,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_wstrb_o,
    input  logic                bus_rsp_valid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_rsp_err_i
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_owner_t          r_owner;
    logic                r_discard;
    logic                r_bus_valid;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [STRB_W-1:0]   r_bus_wstrb;

    logic                w_if_done;
    logic                w_mem_done;
    logic                w_rsp;
    logic                w_abort;
    logic                w_finish;
    logic                w_cap_if;
    logic                w_cap_mem;
    logic [DATA_W-1:0]   w_cap_rdata;
    logic                w_cap_err;

    // Responses are only meaningful in WAIT; anything seen in IDLE or REQ is ignored.
    assign w_rsp = (r_state == ST_WAIT) & bus_rsp_valid_i;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_tmo_cnt;

    assign w_abort = (r_state != ST_IDLE) & ~w_rsp & (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || r_state == ST_IDLE || w_finish) r_tmo_cnt <= '0;
        else                                       r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
`else
    assign w_abort = 1'b0;
`endif

    assign w_finish    = w_rsp | w_abort;
    assign w_cap_rdata = w_rsp ? bus_rdata_i : '0;
    assign w_cap_err   = w_rsp ? bus_rsp_err_i : 1'b1;
    // A flush landing in the same cycle as the response must still drop it.
    assign w_cap_if    = w_finish & (r_owner == OWN_IF) & ~(r_discard | if_flush_i);
    assign w_cap_mem   = w_finish & (r_owner == OWN_MEM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_discard   <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_discard <= 1'b0;
                    if (mem_req_i & ~w_mem_done) begin
                        r_owner     <= OWN_MEM;
                        r_bus_valid <= 1'b1;
                        r_bus_we    <= mem_we_i;
                        r_bus_addr  <= mem_addr_i;
                        r_bus_wdata <= mem_wdata_i;
                        r_bus_wstrb <= mem_wstrb_i;
                        r_state     <= ST_REQ;
                    end else if (if_req_i & ~w_if_done) begin
                        r_owner     <= OWN_IF;
                        r_bus_valid <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= if_addr_i;
                        r_bus_wdata <= '0;
                        r_bus_wstrb <= '0;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if ((r_owner == OWN_IF) & if_flush_i) r_discard <= 1'b1;
                    if (w_abort) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (bus_req_ready_i) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if ((r_owner == OWN_IF) & if_flush_i) r_discard <= 1'b1;
                    if (w_finish) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_buf (
        .clk        (clk),
        .rst        (rst),
        .i_req      (if_req_i),
        .i_addr     (if_addr_i),
        .i_flush    (if_flush_i),
        .i_cap      (w_cap_if),
        .i_cap_addr (r_bus_addr),
        .i_cap_rdata(w_cap_rdata),
        .i_cap_err  (w_cap_err),
        .o_done     (w_if_done),
        .o_rdata    (if_rdata_o),
        .o_err      (if_err_o)
    );

    arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_buf (
        .clk        (clk),
        .rst        (rst),
        .i_req      (mem_req_i),
        .i_addr     (mem_addr_i),
        .i_flush    (1'b0),
        .i_cap      (w_cap_mem),
        .i_cap_addr (r_bus_addr),
        .i_cap_rdata(w_cap_rdata),
        .i_cap_err  (w_cap_err),
        .o_done     (w_mem_done),
        .o_rdata    (mem_rdata_o),
        .o_err      (mem_err_o)
    );

    assign ram_stall_valid_if_o  = if_req_i & ~w_if_done;
    assign ram_stall_valid_mem_o = mem_req_i & ~w_mem_done;

    assign bus_req_valid_o = r_bus_valid;
    assign bus_we_o        = r_bus_we;
    assign bus_addr_o      = r_bus_addr;
    assign bus_wdata_o     = r_bus_wdata;
    assign bus_wstrb_o     = r_bus_wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle checks plus a randomized IF/MEM/bus
// run scored against a transaction-level model. Timeout case needs ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req, if_flush, mem_req, mem_we;
    logic [AW-1:0] if_addr, mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          bus_ready, bus_rsp, bus_rerr;
    logic [DW-1:0] bus_rdata;
    logic [DW-1:0] if_rdata, mem_rdata, bus_wdata;
    logic          if_err, mem_err, stall_if, stall_mem, bus_valid, bus_we;
    logic [AW-1:0] bus_addr;
    logic [SW-1:0] bus_wstrb;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_rdata_o(if_rdata), .if_err_o(if_err), .ram_stall_valid_if_o(stall_if),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb),
        .mem_rdata_o(mem_rdata), .mem_err_o(mem_err), .ram_stall_valid_mem_o(stall_mem),
        .bus_req_valid_o(bus_valid), .bus_req_ready_i(bus_ready),
        .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_wstrb_o(bus_wstrb),
        .bus_rsp_valid_i(bus_rsp), .bus_rdata_i(bus_rdata), .bus_rsp_err_i(bus_rerr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        if_req = 0; if_addr = '0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        bus_ready = 0; bus_rsp = 0; bus_rdata = '0; bus_rerr = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        nxt(); nxt();
        rst = 0;
    endtask

    // Slave response model: data and error are pure functions of the address.
    function automatic logic [DW-1:0] rd_f(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction
    function automatic logic err_f(input logic [AW-1:0] a);
        return a[5:2] == 4'hF;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bvalid"}, bus_valid, 0);
        chk({tag, "_bwe"}, bus_we, 0);
        chk({tag, "_baddr"}, bus_addr, 0);
        chk({tag, "_bwdata"}, bus_wdata, 0);
        chk({tag, "_bwstrb"}, bus_wstrb, 0);
        chk({tag, "_ifrd"}, if_rdata, 0);
        chk({tag, "_memrd"}, mem_rdata, 0);
        chk({tag, "_iferr"}, if_err, 0);
        chk({tag, "_memerr"}, mem_err, 0);
    endtask

    // Random-phase state
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;
    logic [SW-1:0] hold_wstrb;
    logic          hold_we;
    logic [AW-1:0] paddr;
    bit            hold_prev, pend, if_adv, mem_adv, stop;
    int            dly, if_iss, mem_iss, if_wait, mem_wait, if_cnt, mem_cnt;

    initial begin
        idle_in();
        do_reset();
        @(negedge clk);
        chk_all_zero("reset");
        chk("reset_stall_if", stall_if, 0);
        chk("reset_stall_mem", stall_mem, 0);

        // IF-only fetch: ready at 1, response at 3, data at 4
        nxt(); if_req = 1; if_addr = 32'h8000_0000;
        @(negedge clk); chk("t1_c0_stall", stall_if, 1); chk("t1_c0_valid", bus_valid, 0);
        nxt(); bus_ready = 1;
        @(negedge clk); chk("t1_c1_valid", bus_valid, 1); chk("t1_c1_addr", bus_addr, 32'h8000_0000);
        chk("t1_c1_we", bus_we, 0); chk("t1_c1_stall", stall_if, 1);
        nxt(); bus_ready = 0;
        @(negedge clk); chk("t1_c2_valid", bus_valid, 0); chk("t1_c2_stall", stall_if, 1);
        nxt(); bus_rsp = 1; bus_rdata = 32'h13;
        @(negedge clk); chk("t1_c3_stall", stall_if, 1);
        nxt(); bus_rsp = 0; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk); chk("t1_c4_stall", stall_if, 0); chk("t1_c4_rdata", if_rdata, 32'h13);
        chk("t1_c4_err", if_err, 0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            @(negedge clk); chk("t1_noreissue", bus_valid, 0); chk("t1_hold_stall", stall_if, 0);
        end
        nxt(); if_req = 0;

        // Simultaneous IF and MEM: MEM goes first
        nxt(); if_req = 1; if_addr = 32'h100; mem_req = 1; mem_we = 0; mem_addr = 32'h2000;
        @(negedge clk); chk("t2_c0_sif", stall_if, 1); chk("t2_c0_smem", stall_mem, 1);
        nxt(); bus_ready = 1;
        @(negedge clk); chk("t2_c1_valid", bus_valid, 1); chk("t2_c1_addr", bus_addr, 32'h2000);
        nxt(); bus_ready = 0; bus_rsp = 1; bus_rdata = 32'hAAAA_0001;
        @(negedge clk); chk("t2_c2_smem", stall_mem, 1);
        nxt(); bus_rsp = 0;
        @(negedge clk); chk("t2_c3_smem", stall_mem, 0); chk("t2_c3_memrd", mem_rdata, 32'hAAAA_0001);
        chk("t2_c3_sif", stall_if, 1); chk("t2_c3_valid", bus_valid, 0);
        nxt(); bus_ready = 1;
        @(negedge clk); chk("t2_c4_valid", bus_valid, 1); chk("t2_c4_addr", bus_addr, 32'h100);
        nxt(); bus_ready = 0; bus_rsp = 1; bus_rdata = 32'hBBBB_0002;
        @(negedge clk); chk("t2_c5_sif", stall_if, 1);
        nxt(); bus_rsp = 0;
        @(negedge clk); chk("t2_c6_sif", stall_if, 0); chk("t2_c6_ifrd", if_rdata, 32'hBBBB_0002);
        chk("t2_c6_smem", stall_mem, 0);
        nxt(); if_req = 0; mem_req = 0;

        // Flush during WAIT, then new address 0x200
        nxt(); if_req = 1; if_addr = 32'h180;
        nxt(); bus_ready = 1;
        nxt(); bus_ready = 0; if_flush = 1;
        nxt(); if_flush = 0; if_addr = 32'h200; bus_rsp = 1; bus_rdata = 32'hDEAD_0003;
        @(negedge clk); chk("t3_c3_sif", stall_if, 1);
        nxt(); bus_rsp = 0;
        @(negedge clk); chk("t3_c4_sif", stall_if, 1); chk("t3_c4_ifrd", if_rdata, 32'hBBBB_0002);
        chk("t3_c4_valid", bus_valid, 0);
        nxt(); bus_ready = 1;
        @(negedge clk); chk("t3_c5_valid", bus_valid, 1); chk("t3_c5_addr", bus_addr, 32'h200);
        nxt(); bus_ready = 0; bus_rsp = 1; bus_rdata = 32'h77;
        nxt(); bus_rsp = 0;
        @(negedge clk); chk("t3_c7_sif", stall_if, 0); chk("t3_c7_ifrd", if_rdata, 32'h77);
        nxt(); if_req = 0;

        // Store held off by ready for 5 cycles
        nxt(); mem_req = 1; mem_we = 1; mem_addr = 32'h2040; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'h3;
        for (int k = 1; k <= 5; k++) begin
            nxt();
            @(negedge clk);
            chk("t4_valid", bus_valid, 1); chk("t4_we", bus_we, 1); chk("t4_addr", bus_addr, 32'h2040);
            chk("t4_wdata", bus_wdata, 32'hDEAD_BEEF); chk("t4_wstrb", bus_wstrb, 4'h3);
        end
        nxt(); bus_ready = 1;
        @(negedge clk); chk("t4_c6_valid", bus_valid, 1);
        nxt(); bus_ready = 0; bus_rsp = 1; bus_rerr = 0;
        nxt(); bus_rsp = 0;
        @(negedge clk); chk("t4_c8_smem", stall_mem, 0); chk("t4_c8_err", mem_err, 0);
        nxt(); mem_req = 0; mem_we = 0;

        // Error response on a load
        nxt(); mem_req = 1; mem_addr = 32'h2080;
        nxt(); bus_ready = 1;
        nxt(); bus_ready = 0; bus_rsp = 1; bus_rerr = 1; bus_rdata = 32'h5555;
        nxt(); bus_rsp = 0; bus_rerr = 0;
        @(negedge clk); chk("t5_err", mem_err, 1); chk("t5_smem", stall_mem, 0);
        nxt(); mem_req = 0;

`ifdef ARB_TIMEOUT_EN
        // Watchdog: no response ever arrives
        nxt(); if_req = 1; if_addr = 32'h380;
        nxt(); bus_ready = 1;
        nxt(); bus_ready = 0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk); chk("t7_stall", stall_if, 1);
            nxt();
        end
        @(negedge clk); chk("t7_c9_stall", stall_if, 0); chk("t7_c9_err", if_err, 1);
        chk("t7_c9_rdata", if_rdata, 0); chk("t7_c9_valid", bus_valid, 0);
        nxt(); bus_rsp = 1; bus_rdata = 32'h9999;
        nxt(); bus_rsp = 0;
        @(negedge clk); chk("t7_late_rsp", if_rdata, 0);
        nxt(); if_req = 0;
`endif

        // Reset mid-WAIT, then a stray response
        nxt(); if_req = 1; if_addr = 32'h300;
        nxt(); bus_ready = 1;
        nxt(); bus_ready = 0;
        nxt(); rst = 1; if_req = 0;
        nxt(); rst = 0; bus_rsp = 1; bus_rdata = 32'h1234;
        @(negedge clk); chk_all_zero("t6_rst"); chk("t6_sif", stall_if, 0);
        nxt(); bus_rsp = 0;
        @(negedge clk); chk_all_zero("t6_stray");

        // Randomized run against the response-function model
        do_reset();
        hold_prev = 0; pend = 0; if_adv = 0; mem_adv = 0; stop = 0;
        if_iss = 0; mem_iss = 0; if_wait = 0; mem_wait = 0; if_cnt = 0; mem_cnt = 0; dly = 0;
        paddr = '0; hold_addr = '0; hold_wdata = '0; hold_wstrb = '0; hold_we = 0;
        for (int cyc = 0; cyc < 3000 && !stop; cyc++) begin
            nxt();
            if (if_adv || (!if_req && $urandom_range(0, 1) == 1)) begin
                logic [AW-1:0] na;
                if_adv = 0;
                if ($urandom_range(0, 3) == 0) if_req = 0;
                else begin
                    na = 32'h100 + 4 * $urandom_range(0, 63);
                    if (na == if_addr) na = na ^ 32'h4;
                    if_addr = na; if_req = 1;
                end
            end
            if (mem_adv || (!mem_req && $urandom_range(0, 2) == 0)) begin
                logic [AW-1:0] na;
                mem_adv = 0;
                if ($urandom_range(0, 2) == 0) mem_req = 0;
                else begin
                    na = 32'h2000 + 4 * $urandom_range(0, 63);
                    if (na == mem_addr) na = na ^ 32'h4;
                    mem_addr = na; mem_req = 1; mem_we = $urandom_range(0, 1);
                    mem_wdata = $urandom; mem_wstrb = SW'($urandom);
                end
            end
            bus_rsp = 0; bus_rdata = $urandom; bus_rerr = $urandom_range(0, 1);
            if (pend) begin
                if (dly == 0) begin
                    bus_rsp = 1; bus_rdata = rd_f(paddr); bus_rerr = err_f(paddr); pend = 0;
                end else dly--;
            end
            bus_ready = bus_valid && (TMO || $urandom_range(0, 2) == 0);

            @(negedge clk);
            if (hold_prev) begin
                chk("rnd_valid_held", bus_valid, 1);
                chk("rnd_addr_stable", bus_addr, hold_addr);
                chk("rnd_we_stable", bus_we, hold_we);
                chk("rnd_wdata_stable", bus_wdata, hold_wdata);
                chk("rnd_wstrb_stable", bus_wstrb, hold_wstrb);
            end
            hold_prev = 0;
            if (bus_valid && bus_ready) begin
                if (bus_addr < 32'h1000) begin
                    if_iss++;
                    chk("rnd_if_addr", bus_addr, if_addr); chk("rnd_if_we", bus_we, 0);
                end else begin
                    mem_iss++;
                    chk("rnd_mem_addr", bus_addr, mem_addr); chk("rnd_mem_we", bus_we, mem_we);
                    if (mem_we) begin
                        chk("rnd_mem_wdata", bus_wdata, mem_wdata);
                        chk("rnd_mem_wstrb", bus_wstrb, mem_wstrb);
                    end
                end
                paddr = bus_addr; pend = 1; dly = TMO ? $urandom_range(0, 2) : $urandom_range(0, 3);
            end else if (bus_valid) begin
                hold_prev = 1; hold_addr = bus_addr; hold_we = bus_we;
                hold_wdata = bus_wdata; hold_wstrb = bus_wstrb;
            end
            if (if_req && !stall_if) begin
                chk("rnd_if_rdata", if_rdata, rd_f(if_addr));
                chk("rnd_if_err", if_err, err_f(if_addr));
                chk("rnd_if_issues", if_iss, 1);
                if_iss = 0; if_wait = 0; if_adv = 1; if_cnt++;
            end else if (if_req) if_wait++;
            if (mem_req && !stall_mem) begin
                if (!mem_we) chk("rnd_mem_rdata", mem_rdata, rd_f(mem_addr));
                chk("rnd_mem_err", mem_err, err_f(mem_addr));
                chk("rnd_mem_issues", mem_iss, 1);
                mem_iss = 0; mem_wait = 0; mem_adv = 1; mem_cnt++;
            end else if (mem_req) mem_wait++;
            if (if_wait > 200 || mem_wait > 200) begin
                chk("rnd_liveness_timeout", 0, 1);
                stop = 1;
            end
        end
        chk("rnd_if_progress", (if_cnt > 50), 1);
        chk("rnd_mem_progress", (mem_cnt > 50), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
